// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single add/subtract sequencer (optional status flags via FP_STATUS_FLAGS_EN)
module fp_addsub_seq #(
    parameter int          ALIGN_LIMIT = 25,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FP_STATUS_FLAGS_EN
    ,
    output logic [3:0]  out_flags
`endif
);
    typedef enum logic [2:0] {IDLE, CHECK, ALIGN, ADD, NORM, DONE} state_t;
    localparam logic [7:0] LIM = 8'(ALIGN_LIMIT);
    state_t      r_state, w_next;
    logic [31:0] r_a, r_b, r_result;
    logic        r_sg, r_sl;
    logic [7:0]  r_exp;
    logic [23:0] r_mg, r_ml;
    logic [24:0] r_mant;
    logic [4:0]  r_cnt;
    logic [7:0]  w_ea, w_eb, w_eg, w_el, w_diff;
    logic [22:0] w_fa, w_fb;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_special, w_invalid, w_a_big, w_far, w_left;
    logic [23:0] w_mg, w_ml;
    logic [24:0] w_sum;
    logic [31:0] w_special_res, w_norm_res;

    // Operand decode: flush denormals, classify specials, order by magnitude
    always_comb begin
        w_ea          = r_a[30:23];
        w_eb          = r_b[30:23];
        w_fa          = (w_ea == 8'd0) ? 23'd0 : r_a[22:0];
        w_fb          = (w_eb == 8'd0) ? 23'd0 : r_b[22:0];
        w_nan_a       = (&w_ea) && (|w_fa);
        w_nan_b       = (&w_eb) && (|w_fb);
        w_inf_a       = (&w_ea) && !(|w_fa);
        w_inf_b       = (&w_eb) && !(|w_fb);
        w_special     = w_nan_a || w_nan_b || w_inf_a || w_inf_b;
        w_invalid     = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_a[31] != r_b[31]));
        w_special_res = w_invalid ? NAN_PATTERN : w_inf_a ? {r_a[31], 8'hFF, 23'd0} : {r_b[31], 8'hFF, 23'd0};
        w_a_big       = {w_ea, w_fa} >= {w_eb, w_fb};
        w_eg          = w_a_big ? w_ea : w_eb;
        w_el          = w_a_big ? w_eb : w_ea;
        w_mg          = w_a_big ? {|w_ea, w_fa} : {|w_eb, w_fb};
        w_ml          = w_a_big ? {|w_eb, w_fb} : {|w_ea, w_fa};
        w_diff        = w_eg - w_el;
        w_far         = w_diff >= LIM;
        w_sum         = (r_sg == r_sl) ? {1'b0, r_mg} + {1'b0, r_ml} : {1'b0, r_mg} - {1'b0, r_ml};
        w_left        = (r_mant != 25'd0) && !r_mant[23] && (r_exp != 8'd0);
        w_norm_res    = (r_mant == 25'd0) ? 32'd0 :
                        (r_exp == 8'hFF)  ? {r_sg, 8'hFF, 23'd0} :
                        (r_exp == 8'd0)   ? {r_sg, 31'd0} : {r_sg, r_exp, r_mant[22:0]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? CHECK : IDLE;
            CHECK:   w_next = w_special ? DONE : ALIGN;
            ALIGN:   w_next = (r_cnt == 5'd0) ? ADD : ALIGN;
            ADD:     w_next = NORM;
            NORM:    w_next = (r_mant[24] || w_left) ? NORM : DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, align, add, normalize, pack the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_sg     <= 1'b0;
            r_sl     <= 1'b0;
            r_exp    <= '0;
            r_mg     <= '0;
            r_ml     <= '0;
            r_mant   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a <= in_a;
                    r_b <= {in_b[31] ^ in_op, in_b[30:0]};
                end
                CHECK: if (w_special) r_result <= w_special_res;
                else begin
                    r_sg  <= w_a_big ? r_a[31] : r_b[31];
                    r_sl  <= w_a_big ? r_b[31] : r_a[31];
                    r_exp <= w_eg;
                    r_mg  <= w_mg;
                    r_ml  <= w_far ? 24'd0 : w_ml;
                    r_cnt <= w_far ? 5'd0 : w_diff[4:0];
                end
                ALIGN: if (r_cnt != 5'd0) begin
                    r_ml  <= r_ml >> 1;
                    r_cnt <= r_cnt - 5'd1;
                end
                ADD: r_mant <= w_sum;
                NORM: if (r_mant[24]) begin
                    r_mant <= r_mant >> 1;
                    r_exp  <= r_exp + 8'd1;
                end else if (w_left) begin
                    r_mant <= r_mant << 1;
                    r_exp  <= r_exp - 8'd1;
                end else r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

`ifdef FP_STATUS_FLAGS_EN
    logic [3:0] r_flags;

    // Status flags {invalid, overflow, underflow, zero}, settled alongside the result
    always_ff @(posedge clk) begin
        if (rst) r_flags <= '0;
        else if (r_state == CHECK && w_special) r_flags <= {w_invalid, 3'b000};
        else if (r_state == NORM && !r_mant[24] && !w_left)
            r_flags <= {1'b0, (r_mant != 25'd0) && (r_exp == 8'hFF), (r_mant != 25'd0) && (r_exp == 8'd0),
                        (r_mant == 25'd0) || (r_exp == 8'd0)};
    end

    assign out_flags = r_flags;
`endif

    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
endmodule
